// File: rtl/pixel_plotter.sv
// pixel_plotter: buffers (x, y, colour) plot requests in a small FIFO and streams them as
// single-port framebuffer writes. Full-screen clear is built only with STARFLUX_PLOTTER_CLEAR_EN.
module pixel_plotter #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 15
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        x,
    input  logic [6:0]        y,
    input  logic [2:0]        colour,
    input  logic              plot,
    output logic              ready,
    input  logic              clear,
    input  logic [2:0]        clear_colour,
    output logic              busy,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [2:0]        fb_data,
    output logic              fb_we,
    output logic              dropped
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + 3;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [8:0]       X_LIM    = 9'(WIDTH);
    localparam logic [7:0]       Y_LIM    = 8'(HEIGHT);

    typedef enum logic [1:0] {STREAM, DRAIN, CLEAR} state_t;
    state_t state_reg, state_next;

    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [ADDR_W-1:0] req_addr, head_addr;
    logic [2:0]        head_data;
    logic              in_range, push, pop;

    logic              ready_reg, ready_next;
    logic              busy_reg, busy_next;
    logic              fb_we_reg, fb_we_next;
    logic [ADDR_W-1:0] fb_addr_reg, fb_addr_next;
    logic [2:0]        fb_data_reg, fb_data_next;
    logic              dropped_reg, dropped_next;

`ifdef STARFLUX_PLOTTER_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    logic [ADDR_W-1:0] clear_addr_reg;
    logic [2:0]        clear_col_reg;
`else
    logic unused_clear;
    assign unused_clear = ^{clear, clear_colour};
`endif

    // Linear address y*WIDTH + x; shift-add form for the native 160-pixel width.
    generate
        if (WIDTH == 160) begin : g_addr_shift
            assign req_addr = (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
        end else begin : g_addr_mul
            assign req_addr = ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
        end
    endgenerate

    assign in_range = ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
    assign {head_addr, head_data} = fifo_mem[rd_ptr_reg];

    always_comb begin
        push       = plot && ready_reg && in_range;
        pop        = (state_reg != CLEAR) && (count_reg != '0);
        count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end

    // FSM: state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= STREAM;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
`ifdef STARFLUX_PLOTTER_CLEAR_EN
        case (state_reg)
            STREAM:  if (clear) state_next = DRAIN;
            DRAIN:   if (count_next == '0) state_next = CLEAR;
            CLEAR:   if (clear_addr_reg == LAST_ADDR) state_next = STREAM;
            default: state_next = STREAM;
        endcase
`else
        state_next = STREAM;
`endif
    end

    // FSM: outputs (next values of the registered outputs)
    always_comb begin
        fb_we_next   = 1'b0;
        fb_addr_next = fb_addr_reg;
        fb_data_next = fb_data_reg;
        if (pop) begin
            fb_we_next   = 1'b1;
            fb_addr_next = head_addr;
            fb_data_next = head_data;
        end
`ifdef STARFLUX_PLOTTER_CLEAR_EN
        if (state_reg == CLEAR) begin
            fb_we_next   = 1'b1;
            fb_addr_next = clear_addr_reg;
            fb_data_next = clear_col_reg;
        end
        busy_next = (state_next != STREAM);
`else
        busy_next = 1'b0;
`endif
        // Requiring STREAM on both sides holds ready low for one cycle after the last clear write.
        ready_next   = (state_reg == STREAM) && (state_next == STREAM) && (count_next != FULL_CNT);
        dropped_next = plot && ready_reg && !in_range;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {req_addr, colour};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            ready_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            fb_we_reg   <= 1'b0;
            fb_addr_reg <= '0;
            fb_data_reg <= '0;
            dropped_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg   <= count_next;
            ready_reg   <= ready_next;
            busy_reg    <= busy_next;
            fb_we_reg   <= fb_we_next;
            fb_addr_reg <= fb_addr_next;
            fb_data_reg <= fb_data_next;
            dropped_reg <= dropped_next;
        end
    end

`ifdef STARFLUX_PLOTTER_CLEAR_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clear_addr_reg <= '0;
            clear_col_reg  <= '0;
        end else begin
            if (state_reg == STREAM && clear) clear_col_reg <= clear_colour;
            if (state_reg == CLEAR) clear_addr_reg <= clear_addr_reg + ADDR_W'(1);
            else                    clear_addr_reg <= '0;
        end
    end
`endif

    assign ready   = ready_reg;
    assign busy    = busy_reg;
    assign fb_we   = fb_we_reg;
    assign fb_addr = fb_addr_reg;
    assign fb_data = fb_data_reg;
    assign dropped = dropped_reg;

endmodule

// File: tb/tb_pixel_plotter.sv
// Randomised bench for pixel_plotter: a queue of expected framebuffer writes, built from
// y*WIDTH+x and the range rules, is checked against every fb_we pulse.
module tb_pixel_plotter;
    localparam int WIDTH  = 160;
    localparam int HEIGHT = 120;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [7:0]  x = '0;
    logic [6:0]  y = '0;
    logic [2:0]  colour = '0;
    logic        plot = 1'b0;
    logic        ready;
    logic        clear = 1'b0;
    logic [2:0]  clear_colour = '0;
    logic        busy;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we;
    logic        dropped;

    pixel_plotter dut (
        .clk          (clk),
        .resetn       (resetn),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .plot         (plot),
        .ready        (ready),
        .clear        (clear),
        .clear_colour (clear_colour),
        .busy         (busy),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .fb_we        (fb_we),
        .dropped      (dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  drop_exp = 0;
    int  drop_seen = 0;
    int  stall_cnt = 0;

    task automatic check(input string tag, input int obs, input int expv);
        tests++;
        if (obs != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int a, input int d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Every framebuffer write must match the head of the expected queue.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (dropped) drop_seen++;
        if (fb_we) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", int'(fb_addr), -1);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", int'(fb_addr), e.addr);
                check("wr_data", int'(fb_data), e.data);
            end
        end
    end

    task automatic send(input int px, input int py, input int pc, input bit with_clear, input int ccol);
        bit acc;
        x      = 8'(px);
        y      = 7'(py);
        colour = 3'(pc);
        plot   = 1'b1;
        if (with_clear) begin
            clear        = 1'b1;
            clear_colour = 3'(ccol);
        end
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = ready;
            if (!acc) stall_cnt++;
            @(posedge clk);
            #1;
        end
        plot  = 1'b0;
        clear = 1'b0;
        if (!acc) begin
            check("send_timeout", 0, 1);
        end else if (px < WIDTH && py < HEIGHT) begin
            push_exp(py * WIDTH + px, pc);
            $display("[TB] plot x=%0d y=%0d colour=%0d -> addr %0d", px, py, pc, py * WIDTH + px);
        end else begin
            drop_exp++;
            $display("[TB] plot x=%0d y=%0d colour=%0d -> out of range", px, py, pc);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check(tag, exp_q.size(), 0);
    endtask

    task automatic reset_mid_and_check();
        #2 resetn = 1'b0;
        #1;
        check("abort_we", fb_we, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 0);
        check("abort_addr", int'(fb_addr), 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_abort", ready, 1);
        send(7, 3, 5, 1'b0, 0);
        @(posedge clk);
        #1;
        check("post_abort_we", fb_we, 1);
        check("post_abort_addr", int'(fb_addr), 487);
        check("post_abort_data", int'(fb_data), 5);
        wait_idle("idle_post_abort");
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int busy_cyc;
        int ready_bad;
        int bad;
        bit found;

        #3 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_we", fb_we, 0);
        check("rst_addr", int'(fb_addr), 0);
        check("rst_data", int'(fb_data), 0);
        check("rst_dropped", dropped, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("ready_first_edge", ready, 1);

        // First request: write appears one edge after acceptance, for one cycle.
        send(5, 2, 4, 1'b0, 0);
        @(posedge clk);
        #1;
        check("lat_we", fb_we, 1);
        check("lat_addr", int'(fb_addr), 325);
        check("lat_data", int'(fb_data), 4);
        @(posedge clk);
        #1;
        check("we_one_cycle", fb_we, 0);
        wait_idle("idle_first");

        send(160, 0, 1, 1'b0, 0);
        send(0, 120, 2, 1'b0, 0);
        wait_idle("idle_oor");
        check("drops_oor", drop_seen, drop_exp);

        send(159, 119, 1, 1'b0, 0);
        wait_idle("idle_corner");

        stall_cnt = 0;
        for (int i = 0; i < 8; i++) send(i, 10, int'($urandom_range(0, 7)), 1'b0, 0);
        wait_idle("idle_burst");
        check("burst_no_stall", stall_cnt, 0);
        check("burst_no_drop", drop_seen, drop_exp);

        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(int'($urandom_range(0, 175)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 7)), 1'b0, 0);
        end
        wait_idle("idle_random");
        check("drops_random", drop_seen, drop_exp);

`ifdef STARFLUX_PLOTTER_CLEAR_EN
        // Pixels ahead of the clear (the last on the same edge) are written before the fill.
        send(1, 1, 3, 1'b0, 0);
        send(2, 1, 5, 1'b0, 0);
        send(3, 1, 6, 1'b1, 2);
        for (int a = 0; a < WIDTH * HEIGHT; a++) push_exp(a, 2);
        $display("[TB] clear colour=2 started");
        busy_cyc  = 0;
        ready_bad = 0;
        for (int i = 0; i < 20100 && busy; i++) begin
            busy_cyc++;
            if (ready) ready_bad++;
            if (i == 3) begin
                clear        = 1'b1;
                clear_colour = 3'b101;
            end else begin
                clear = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        clear = 1'b0;
        check("busy_length_ok", int'(busy_cyc >= 19200 && busy_cyc <= 19204), 1);
        check("ready_low_busy", ready_bad, 0);
        check("busy_end", busy, 0);
        check("ready_hold_after_clear", ready, 0);
        @(posedge clk);
        #1;
        check("ready_back", ready, 1);
        wait_idle("idle_clear");

        clear_colour = 3'd6;
        clear        = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        for (int a = 0; a < WIDTH * HEIGHT; a++) push_exp(a, 6);
        $display("[TB] clear colour=6 started, reset at address 5000");
        found = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            @(posedge clk);
            #1;
            found = fb_we && (fb_addr == 15'd5000);
        end
        check("reach_5000", int'(found), 1);
        reset_mid_and_check();
`else
        clear_colour = 3'b010;
        clear        = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        $display("[TB] clear pulse (feature not built)");
        bad = 0;
        repeat (30) begin
            if (busy || !ready) bad++;
            @(posedge clk);
            #1;
        end
        check("clear_ignored", bad, 0);
        wait_idle("idle_noclear");

        // Pending request is discarded by reset before it is written.
        send(9, 9, 3, 1'b0, 0);
        reset_mid_and_check();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pixel_plotter.md
# pixel_plotter

Consumer side of the pixel stream produced by the game's display scanner. Accepts (x, y, colour) plot requests through a valid/ready handshake and buffers them in a small FIFO. Converts each request to a linear framebuffer address and drives a single-port write interface into the 160x120x3 framebuffer RAM. Optionally performs a full-screen clear to a chosen colour.

## Interface
- WIDTH, 160, screen width in pixels
- HEIGHT, 120, screen height in pixels
- FIFO_DEPTH, 4, plot request buffer entries (power of two)
- ADDR_W, 15, framebuffer address width (WIDTH*HEIGHT = 19200 < 2^15)

- clk  in  1  system clock (50 MHz on DE2)
- resetn  in  1  asynchronous, active-low reset
- x  in  8  pixel column
- y  in  7  pixel row
- colour  in  3  pixel colour {R,G,B}
- plot  in  1  request valid
- ready  out  1  request accepted when plot && ready at a rising edge
- clear  in  1  clear-screen request (single-cycle pulse)
- clear_colour  in  3  fill colour, sampled with clear
- busy  out  1  clear sequence in progress
- fb_addr  out  ADDR_W  framebuffer write address
- fb_data  out  3  framebuffer write data
- fb_we  out  1  framebuffer write enable
- dropped  out  1  one-cycle pulse: an accepted request had out-of-range coordinates

## Operation
- FSM states: STREAM, DRAIN, CLEAR. Reset state STREAM.
- STREAM: accept requests into FIFO; each cycle FIFO is non-empty, pop one entry and issue one write.
- Address: fb_addr = y*WIDTH + x, computed as (y<<7)+(y<<5)+x for WIDTH=160; full ADDR_W width, no truncation.
- Range check at accept: x >= WIDTH or y >= HEIGHT -> request consumed (handshake completes), not pushed, dropped = 1 on the following cycle.
- Simultaneous push and pop on non-empty FIFO: occupancy unchanged, order preserved (strict FIFO).
- clear pulse in STREAM: latch clear_colour, go to DRAIN. DRAIN: ready low, keep popping until FIFO empty, then CLEAR.
- CLEAR: write latched colour to addresses 0..WIDTH*HEIGHT-1 ascending, one per cycle; after address 19199, return to STREAM.
- busy = 1 in DRAIN and CLEAR. clear while busy is ignored.
- An in-range request presented on the same edge as clear in STREAM is accepted and drained before the clear begins.

## Timing
- All outputs registered. Reset values: ready 0, busy 0, fb_we 0, fb_addr 0, fb_data 0, dropped 0. FIFO empty.
- ready rises on first clk edge after resetn deasserts. ready = 0 when FIFO full or state != STREAM, updated so no request is lost at full.
- Latency: request accepted at edge k into empty FIFO -> fb_we/fb_addr/fb_data valid from edge k+1 for one cycle.
- Throughput: one write per cycle sustained; FIFO absorbs up to FIFO_DEPTH back-pressure cycles.
- Clear duration: DRAIN (≤ FIFO_DEPTH cycles) + 19200 CLEAR cycles. ready returns high the edge after the last clear write.
- resetn asserted mid-operation: immediate abort, all state and outputs to reset values, FIFO contents discarded, partial clear not resumed.

## Configuration
- STARFLUX_PLOTTER_CLEAR_EN defined: clear FSM (DRAIN, CLEAR) present as described.
- Undefined: clear and clear_colour ignored, busy tied 0, FSM fixed in STREAM; ready depends only on FIFO full.

## Test plan
- Reset release, plot (x=5, y=2, colour=100) held one cycle -> fb_we pulse one edge later with fb_addr=325, fb_data=100; ready high from first edge after reset.
- Out-of-range (x=160, y=0) and (x=0, y=120) -> handshake completes, fb_we stays 0, dropped pulses once per request.
- Corner (x=159, y=119, colour=001) -> fb_addr=19199, fb_data=001.
- Hold fb consumer rate at max while plotting 8 back-to-back pixels along row 10 -> 8 writes, addresses 1600..1607 in order, no drops, ready never low.
- Fill FIFO with 3 pixels then pulse clear with clear_colour=010 -> 3 pixel writes first, then 19200 writes of 010 at addresses 0..19199, busy high throughout, ready low until completion; second clear during busy ignored.
- Assert resetn low mid-clear at address 5000 -> fb_we 0 immediately, busy 0; after release, plot accepted normally.
